// File: rtl/two_mode_timer_core.sv
// Two-mode timer counting stage: count register, prescaler and IDLE/RUN/PAUSE/DONE control
// around an 8-bit ripple incrementor (stopwatch) and decrementor (countdown).

module two_mode_timer_incr8 (
   input  logic [7:0] a,
   output logic [7:0] y
);
   logic [7:0] carry;

   assign carry[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit
         assign y[gi] = a[gi] ^ carry[gi];
         if (gi < 7) begin : g_carry
            assign carry[gi+1] = a[gi] & carry[gi];
         end
      end
   endgenerate
endmodule

module two_mode_timer_decr8 (
   input  logic [7:0] a,
   output logic [7:0] y
);
   logic [7:0] borrow;

   assign borrow[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit
         assign y[gi] = a[gi] ^ borrow[gi];
         if (gi < 7) begin : g_borrow
            assign borrow[gi+1] = ~a[gi] & borrow[gi];
         end
      end
   endgenerate
endmodule

module two_mode_timer_core #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             running,
   output logic             wrap,
   output logic             done
);
   localparam int PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic [PW-1:0]    presc_reg, presc_next;
   logic             wrap_reg, wrap_next;
   logic [7:0]       inc_val, dec_val;

   two_mode_timer_incr8 u_incr (
      .a (count_reg),
      .y (inc_val)
   );

   two_mode_timer_decr8 u_decr (
      .a (count_reg),
      .y (dec_val)
   );

   assign tick    = (state_reg == RUN) && (presc_reg == PRESC_MAX);
   assign count   = count_reg;
   assign running = (state_reg == RUN);
   assign done    = (state_reg == DONE);
   assign wrap    = wrap_reg;

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      presc_next = presc_reg;
      wrap_next  = 1'b0;

      if (load) begin
         count_next = load_val;
         presc_next = '0;
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start && !stop) begin
                  presc_next = '0;
                  state_next = (mode && count_reg == '0) ? DONE : RUN;
               end
            end
            PAUSE: begin
               if (start && !stop) begin
                  state_next = (mode && count_reg == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               // A stop landing on a tick still completes that period; otherwise the
               // prescaler is frozen so a resume continues mid-period.
               if (tick) begin
                  presc_next = '0;
               end else if (!stop) begin
                  presc_next = presc_reg + 1'b1;
               end
               if (stop) begin
                  state_next = PAUSE;
               end
               if (tick) begin
                  if (!mode) begin
                     count_next = inc_val;
                     wrap_next  = (count_reg == 8'hFF);
                  end else if (count_reg <= 8'h01) begin
                     // Countdown never underflows: reaching (or sitting at) zero ends the run.
                     count_next = '0;
                     state_next = DONE;
                  end else begin
                     count_next = dec_val;
                  end
               end
            end
            DONE: begin
               state_next = DONE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         count_reg <= '0;
         presc_reg <= '0;
         wrap_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         presc_reg <= presc_next;
         wrap_reg  <= wrap_next;
      end
   end
endmodule
